// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - tile-by-tile weight memory reader feeding the systolic array load port
// Define WLC_PREFETCH_EN to fetch the next tile in the background while one is presented.
module weight_load_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int STRIDE = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  num_tiles_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_w0_i,
  input  logic [DATA_W-1:0] mem_w1_i,
  input  logic [DATA_W-1:0] mem_w2_i,
  input  logic [DATA_W-1:0] mem_w3_i,
  output logic              load_valid_o,
  input  logic              load_ready_i,
  output logic [DATA_W-1:0] load_w0_o,
  output logic [DATA_W-1:0] load_w1_o,
  output logic [DATA_W-1:0] load_w2_o,
  output logic [DATA_W-1:0] load_w3_o,
  output logic [CNT_W-1:0]  tile_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e                   state_q;
  logic [ADDR_W-1:0]        cur_addr_q;
  logic [ADDR_W-1:0]        cur_addr_d;
  logic [ADDR_W-1:0]        mem_addr_q;
  logic [CNT_W-1:0]         remaining_q;
  logic [CNT_W-1:0]         tile_idx_q;
  logic [3:0][DATA_W-1:0]   load_w_q;
  logic [3:0][DATA_W-1:0]   mem_w;
  logic                     load_valid_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     handshake;
`ifdef WLC_PREFETCH_EN
  logic [3:0][DATA_W-1:0]   pf_w_q;
  logic                     pf_valid_q;
`endif

  assign mem_w      = {mem_w3_i, mem_w2_i, mem_w1_i, mem_w0_i};
  assign cur_addr_d = cur_addr_q + STRIDE_A;
  assign handshake  = load_valid_q & load_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      mem_addr_q   <= '0;
      remaining_q  <= '0;
      tile_idx_q   <= '0;
      load_w_q     <= '0;
      load_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef WLC_PREFETCH_EN
      pf_w_q       <= '0;
      pf_valid_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort_i && state_q != S_IDLE) begin
        // Abort beats a same-cycle handshake: nothing of this tile is committed.
        state_q      <= S_IDLE;
        load_valid_q <= 1'b0;
        busy_q       <= 1'b0;
`ifdef WLC_PREFETCH_EN
        pf_valid_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              cur_addr_q  <= base_addr_i;
              remaining_q <= num_tiles_i;
              tile_idx_q  <= '0;
              busy_q      <= 1'b1;
              if (num_tiles_i == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_FETCH;
                mem_addr_q <= base_addr_i;
              end
            end
          end
          S_FETCH: begin
            load_w_q     <= mem_w;
            load_valid_q <= 1'b1;
            state_q      <= S_PRESENT;
`ifdef WLC_PREFETCH_EN
            mem_addr_q   <= cur_addr_d;
            pf_valid_q   <= 1'b0;
`endif
          end
          S_PRESENT: begin
            if (handshake) begin
              cur_addr_q  <= cur_addr_d;
              tile_idx_q  <= tile_idx_q + CNT_ONE;
              remaining_q <= remaining_q - CNT_ONE;
              if (remaining_q == CNT_ONE) begin
                state_q      <= S_DONE;
                load_valid_q <= 1'b0;
                done_q       <= 1'b1;
              end else begin
`ifdef WLC_PREFETCH_EN
                // Next tile is already addressed; present it without a FETCH bubble.
                load_w_q   <= pf_valid_q ? pf_w_q : mem_w;
                mem_addr_q <= cur_addr_d + STRIDE_A;
                pf_valid_q <= 1'b0;
`else
                state_q      <= S_FETCH;
                load_valid_q <= 1'b0;
                mem_addr_q   <= cur_addr_d;
`endif
              end
            end
`ifdef WLC_PREFETCH_EN
            else begin
              pf_w_q     <= mem_w;
              pf_valid_q <= 1'b1;
            end
`endif
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q      <= S_IDLE;
            load_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_addr_o   = mem_addr_q;
  assign load_valid_o = load_valid_q;
  assign load_w0_o    = load_w_q[0];
  assign load_w1_o    = load_w_q[1];
  assign load_w2_o    = load_w_q[2];
  assign load_w3_o    = load_w_q[3];
  assign tile_idx_o   = tile_idx_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb/tb_weight_load_ctrl.sv - directed self-checking bench for weight_load_ctrl
module tb_weight_load_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        abort_i;
  logic [12:0] base_addr_i;
  logic [7:0]  num_tiles_i;
  logic [12:0] mem_addr_o;
  logic [15:0] mem_w0_i, mem_w1_i, mem_w2_i, mem_w3_i;
  logic        load_valid_o;
  logic        load_ready_i;
  logic [15:0] load_w0_o, load_w1_o, load_w2_o, load_w3_o;
  logic [7:0]  tile_idx_o;
  logic        busy_o;
  logic        done_o;

  logic [15:0] mem [0:8191];
  logic [12:0] a1, a2, a3;
  int          errors = 0;
  int          checks = 0;
  int          dn;

  weight_load_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
    .base_addr_i(base_addr_i), .num_tiles_i(num_tiles_i), .mem_addr_o(mem_addr_o),
    .mem_w0_i(mem_w0_i), .mem_w1_i(mem_w1_i), .mem_w2_i(mem_w2_i), .mem_w3_i(mem_w3_i),
    .load_valid_o(load_valid_o), .load_ready_i(load_ready_i),
    .load_w0_o(load_w0_o), .load_w1_o(load_w1_o), .load_w2_o(load_w2_o), .load_w3_o(load_w3_o),
    .tile_idx_o(tile_idx_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  assign a1 = mem_addr_o + 13'd1;
  assign a2 = mem_addr_o + 13'd2;
  assign a3 = mem_addr_o + 13'd3;
  assign mem_w0_i = mem[mem_addr_o];
  assign mem_w1_i = mem[a1];
  assign mem_w2_i = mem[a2];
  assign mem_w3_i = mem[a3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    base_addr_i = '0; num_tiles_i = '0; load_ready_i = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 16'h1000 + 16'(i);
    mem[15] = 16'd3; mem[16] = 16'd5; mem[17] = 16'd4; mem[18] = 16'd6;
    step(); step();
    chk("rst_mem_addr", 32'(mem_addr_o), 0);
    chk("rst_valid", 32'(load_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_tile_idx", 32'(tile_idx_o), 0);
    chk("rst_w0", 32'(load_w0_o), 0);
    rst_n_i = 1'b1;
    step();

    // single tile at 0x000F
    base_addr_i = 13'h000F; num_tiles_i = 8'd1; start_i = 1'b1;
    step(); start_i = 1'b0;
    chk("t1_c1_busy", 32'(busy_o), 1);
    chk("t1_c1_valid", 32'(load_valid_o), 0);
    chk("t1_c1_addr", 32'(mem_addr_o), 32'h000F);
    step();
    chk("t1_c2_valid", 32'(load_valid_o), 1);
    chk("t1_c2_w0", 32'(load_w0_o), 3);
    chk("t1_c2_w1", 32'(load_w1_o), 5);
    chk("t1_c2_w2", 32'(load_w2_o), 4);
    chk("t1_c2_w3", 32'(load_w3_o), 6);
    chk("t1_c2_idx", 32'(tile_idx_o), 0);
    step();
    chk("t1_c3_done", 32'(done_o), 1);
    chk("t1_c3_busy", 32'(busy_o), 1);
    chk("t1_c3_valid", 32'(load_valid_o), 0);
    step();
    chk("t1_c4_busy", 32'(busy_o), 0);
    chk("t1_c4_done", 32'(done_o), 0);
    chk("t1_c4_addr_hold", 32'(mem_addr_o), 32'h000F);

    // three tiles at 0x0010, ready high
    base_addr_i = 13'h0010; num_tiles_i = 8'd3; start_i = 1'b1;
    step(); start_i = 1'b0;
    dn = 0;
    for (int c = 1; c <= 9; c++) begin
      chk("t2_valid", 32'(load_valid_o), 32'(c == 2 || c == 4 || c == 6));
      if (done_o) dn++;
      if (c == 1) chk("t2_addr0", 32'(mem_addr_o), 32'h0010);
      if (c == 3) chk("t2_addr1", 32'(mem_addr_o), 32'h0014);
      if (c == 5) chk("t2_addr2", 32'(mem_addr_o), 32'h0018);
      if (c == 2) chk("t2_t0_w3", 32'(load_w3_o), 32'h1013);
      if (c == 4) begin
        chk("t2_t1_w0", 32'(load_w0_o), 32'h1014);
        chk("t2_t1_idx", 32'(tile_idx_o), 1);
      end
      if (c == 6) begin
        chk("t2_t2_w0", 32'(load_w0_o), 32'h1018);
        chk("t2_t2_idx", 32'(tile_idx_o), 2);
      end
      if (c == 7) chk("t2_done_c7", 32'(done_o), 1);
      step();
    end
    chk("t2_done_count", 32'(dn), 1);

    // stall with ready low
    load_ready_i = 1'b0;
    base_addr_i = 13'h0020; num_tiles_i = 8'd1; start_i = 1'b1;
    step(); start_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", 32'(load_valid_o), 1);
      chk("t3_stall_w0", 32'(load_w0_o), 32'h1020);
      chk("t3_stall_w3", 32'(load_w3_o), 32'h1023);
      chk("t3_stall_done", 32'(done_o), 0);
      step();
    end
    load_ready_i = 1'b1;
    chk("t3_still_valid", 32'(load_valid_o), 1);
    step();
    chk("t3_done", 32'(done_o), 1);
    step();

    // address wrap
    base_addr_i = 13'h1FFC; num_tiles_i = 8'd2; start_i = 1'b1;
    step(); start_i = 1'b0;
    chk("t4_addr0", 32'(mem_addr_o), 32'h1FFC);
    step();
    chk("t4_t0_w0", 32'(load_w0_o), 32'h2FFC);
    step();
    chk("t4_addr_wrap", 32'(mem_addr_o), 0);
    step();
    chk("t4_t1_w0", 32'(load_w0_o), 32'h1000);
    chk("t4_t1_w3", 32'(load_w3_o), 32'h1003);
    chk("t4_t1_idx", 32'(tile_idx_o), 1);
    step();
    chk("t4_done", 32'(done_o), 1);
    step();

    // zero tiles
    base_addr_i = 13'h0030; num_tiles_i = 8'd0; start_i = 1'b1;
    step(); start_i = 1'b0;
    chk("t5_zero_done", 32'(done_o), 1);
    chk("t5_zero_busy", 32'(busy_o), 1);
    chk("t5_zero_valid", 32'(load_valid_o), 0);
    step();
    chk("t5_zero_idle", 32'(busy_o), 0);
    chk("t5_zero_valid2", 32'(load_valid_o), 0);

    // start while busy is ignored
    load_ready_i = 1'b0;
    base_addr_i = 13'h0040; num_tiles_i = 8'd1; start_i = 1'b1;
    step();
    base_addr_i = 13'h0080; num_tiles_i = 8'd5;
    step(); start_i = 1'b0;
    chk("t5_busy_addr", 32'(mem_addr_o), 32'h0040);
    chk("t5_busy_w0", 32'(load_w0_o), 32'h1040);
    load_ready_i = 1'b1;
    step();
    chk("t5_busy_done", 32'(done_o), 1);
    step();
    chk("t5_busy_idle", 32'(busy_o), 0);

    // abort while presenting tile 1 of 4
    base_addr_i = 13'h0100; num_tiles_i = 8'd4; start_i = 1'b1;
    step(); start_i = 1'b0;
    step(); step(); step();
    chk("t6_t1_valid", 32'(load_valid_o), 1);
    chk("t6_t1_idx", 32'(tile_idx_o), 1);
    chk("t6_t1_w0", 32'(load_w0_o), 32'h1104);
    abort_i = 1'b1;
    step(); abort_i = 1'b0;
    chk("t6_abort_busy", 32'(busy_o), 0);
    chk("t6_abort_valid", 32'(load_valid_o), 0);
    chk("t6_abort_done", 32'(done_o), 0);
    step();
    chk("t6_abort_done2", 32'(done_o), 0);
    chk("t6_abort_busy2", 32'(busy_o), 0);
    start_i = 1'b1; abort_i = 1'b1; num_tiles_i = 8'd1;
    step(); start_i = 1'b0; abort_i = 1'b0;
    chk("t6_abort_start_busy", 32'(busy_o), 0);
    step();
    chk("t6_abort_start_valid", 32'(load_valid_o), 0);

    // asynchronous reset mid-sequence
    base_addr_i = 13'h0200; num_tiles_i = 8'd2; start_i = 1'b1;
    step(); start_i = 1'b0;
    step();
    chk("t7_pre_valid", 32'(load_valid_o), 1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(load_valid_o), 0);
    chk("t7_rst_busy", 32'(busy_o), 0);
    chk("t7_rst_addr", 32'(mem_addr_o), 0);
    chk("t7_rst_w0", 32'(load_w0_o), 0);
    chk("t7_rst_idx", 32'(tile_idx_o), 0);
    step();
    rst_n_i = 1'b1;
    step();
    chk("t7_post_done", 32'(done_o), 0);
    chk("t7_post_busy", 32'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
